mul32x32_seq_ctrl: RTL



---
 rtl/mul_pkg.sv | 34 +++
 rtl/mul_slice_acc.sv | 33 +++
 rtl/mul32x32_seq_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and constants for the 32x32 sequential multiplier controller.
// Optional early-exit feature is enabled by defining MUL_EARLY_EXIT_EN.
package mul_pkg;

  localparam int A_W        = 32;
  localparam int B_W        = 32;
  localparam int SLICE_W    = 8;
  localparam int Y_W        = 40;
  localparam int P_W        = 64;
  localparam int NUM_SLICES = 4;
  localparam int K_W        = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // True when no nonzero multiplier bits remain above slice k.
  function automatic logic upper_zero(
    input logic [B_W-1:0] b,
    input logic [K_W-1:0] k
  );
    logic z;
    unique case (k)
      2'd0:    z = (b[31:8] == 24'd0);
      2'd1:    z = (b[31:16] == 16'd0);
      2'd2:    z = (b[31:24] == 8'd0);
      default: z = 1'b1;
    endcase
    return z;
  endfunction

endpackage

// File: rtl/mul_slice_acc.sv
// 64-bit shift-accumulator for byte-slice partial products.
// Aligns each 40-bit slice product by 8*k and adds it into the running sum.
module mul_slice_acc
  import mul_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           en,
  input  logic [K_W-1:0] k,
  input  logic [Y_W-1:0] mul_y,
  output logic [P_W-1:0] acc
);

  logic [P_W-1:0] aligned;

  // Place the slice product at its byte weight within the 64-bit sum.
  always_comb begin
    aligned = {{(P_W-Y_W){1'b0}}, mul_y} << {k, 3'b000};
  end

  // Clear on a new operand pair, accumulate once per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + aligned;
    end
  end

endmodule

// File: rtl/mul32x32_seq_ctrl.sv
// 32x32 unsigned multiply sequenced over an external 32x8 array multiplier.
// Define MUL_EARLY_EXIT_EN to stop once remaining multiplier slices are zero.
module mul32x32_seq_ctrl
  import mul_pkg::*;
#(
  parameter int NUM_SLICES = 4,
  parameter int SLICE_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_W-1:0]     in_a,
  input  logic [B_W-1:0]     in_b,
  output logic [A_W-1:0]     mul_a,
  output logic [SLICE_W-1:0] mul_b,
  input  logic [Y_W-1:0]     mul_y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P_W-1:0]     out_p,
  output logic               busy
);

  state_t         state;
  logic [A_W-1:0] a_reg;
  logic [B_W-1:0] b_reg;
  logic [K_W-1:0] k;
  logic [P_W-1:0] acc;
  logic           accept;
  logic           k_last;
  logic           run_end;

  assign accept = (state == IDLE) && in_valid;
  assign k_last = (k == K_W'(NUM_SLICES - 1));

`ifdef MUL_EARLY_EXIT_EN
  assign run_end = k_last || upper_zero(b_reg, k);
`else
  assign run_end = k_last;
`endif

  // Array operands come straight from the latched registers.
  always_comb begin
    mul_a = a_reg;
    mul_b = b_reg[{k, 3'b000} +: SLICE_W];
  end

  // Handshake flags decode the state register, so reset clears them at once.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    out_p     = acc;
  end

  // Control FSM: latch operands, step through slices, hold result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      k     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= in_a;
            b_reg <= in_b;
            k     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (run_end) begin
            state <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mul_slice_acc u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (state == RUN),
    .k     (k),
    .mul_y (mul_y),
    .acc   (acc)
  );

endmodule
